// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
// Holds the arbiter state encoding, register-file addressing constants and
// the layout of one queued MDU result ({addr, data}, 37 bits).
package wb_arb_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering MDU results until the regfile write port is free.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data write an entry at the tail (ignored when full)
//   pop,  pop_data  remove the head entry; pop_data always shows the head
//   full, empty     occupancy flags
//   count           number of stored entries (clog2(DEPTH)+1 bits)
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback
// stage and the MDU. MDU results queue in a FIFO and drain in idle cycles;
// after STARVE_MAX consecutive pipeline grants with results waiting, the
// pipeline is stalled for one cycle to force a drain.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   wb_we, wb_addr, wb_data       pipeline writeback request
//   wb_stall                      registered pipeline hold (forced drain cycle)
//   mdu_valid/addr/data, mdu_ready MDU result handshake
//   rf_we, rf_waddr, rf_wdata     registered regfile write port
//   pending                       per-register outstanding MDU write mask
//   err_waw                       sticky pipeline-overwrote-pending-register flag
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending,
    output logic        err_waw
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    arb_state_t       state, state_next;
    logic [SC_W-1:0]  starve_cnt, starve_next;
    logic             stall_next;
    logic             pipe_req;
    logic             grant_pipe;
    logic             pop;
    logic             enq;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_has_data;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] head_raw;
    wb_entry_t        head;
    wb_entry_t        enq_entry;
    logic [31:0]      pending_next;

    assign pipe_req      = wb_we && (wb_addr != REG_ZERO);
    assign mdu_ready     = !fifo_full && !pending[mdu_addr];
    assign enq           = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO);
    assign fifo_has_data = (fifo_count != '0);
    assign head          = wb_entry_t'(head_raw);
    assign enq_entry     = '{addr: mdu_addr, data: mdu_data};

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_data (enq_entry),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        stall_next  = 1'b0;
        grant_pipe  = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (pipe_req) begin
                    grant_pipe = 1'b1;
                    if (!fifo_has_data) begin
                        starve_next = '0;
                    end else if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
                        // Counter holds at its ceiling; FORCE clears it.
                        state_next = ST_FORCE;
                        stall_next = 1'b1;
                    end else begin
                        starve_next = starve_cnt + SC_W'(1);
                    end
                end else begin
                    pop         = !fifo_empty;
                    starve_next = '0;
                end
            end
            ST_FORCE: begin
                pop         = !fifo_empty;
                state_next  = ST_NORMAL;
                starve_next = '0;
            end
            default: begin
                state_next  = ST_NORMAL;
                starve_next = '0;
            end
        endcase
    end

    // Enqueue requires pending[mdu_addr]==0, so set and clear never collide.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[head.addr] = 1'b0;
        if (enq) pending_next[mdu_addr]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pending    <= '0;
            err_waw    <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            wb_stall   <= stall_next;
            pending    <= pending_next;
            rf_we      <= grant_pipe || pop;
            if (grant_pipe) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end else if (pop) begin
                rf_waddr <= head.addr;
                rf_wdata <= head.data;
            end
            if (grant_pipe && pending[wb_addr]) err_waw <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: every expected regfile write is queued
// when the stimulus that causes it is driven, and popped/compared whenever
// the DUT asserts rf_we. Status outputs are checked at fixed points.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        err_waw;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [36:0] exp_q[$];

    wb_port_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_stall  (wb_stall),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending),
        .err_waw   (err_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every regfile write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed write r%0d=%h expected none", rf_waddr, rf_wdata);
            end
            if (exp_q.size() > 0) begin
                logic [36:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                assert ({rf_waddr, rf_wdata} === e) else begin
                    n_err++;
                    $error("FAIL sb_write: observed r%0d=%h expected r%0d=%h",
                           rf_waddr, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        mdu_valid = 1'b0;
        mdu_addr  = '0;
        mdu_data  = '0;
        tick();
        tick();
        check("rst_pending",  pending,   32'h0);
        check("rst_rf_we",    {31'd0, rf_we},    32'd0);
        check("rst_stall",    {31'd0, wb_stall}, 32'd0);
        check("rst_err_waw",  {31'd0, err_waw},  32'd0);
        check("rst_ready",    {31'd0, mdu_ready}, 32'd1);
        check("rst_waddr",    {27'd0, rf_waddr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: reset while r5/r6 are queued (pipeline writes keep them queued)
        wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'hA0;
        mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h11;
        expect_wr(5'd20, 32'hA0);
        tick();
        mdu_addr = 5'd6; mdu_data = 32'h22;
        tick();
        check("t1_pending_q", pending, 32'h60);
        rst_n = 1'b0; wb_we = 1'b0; mdu_valid = 1'b0;
        #1;
        check("t1_rst_pending", pending, 32'h0);
        check("t1_rst_rf_we",   {31'd0, rf_we}, 32'd0);
        check("t1_rst_ready",   {31'd0, mdu_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t1_no_drain", pending, 32'h0);

        // 2: idle drain
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hDEADBEEF;
        expect_wr(5'd9, 32'hDEADBEEF);
        tick();
        mdu_valid = 1'b0;
        check("t2_pending9", pending, 32'h200);
        check("t2_no_we",    {31'd0, rf_we}, 32'd0);
        tick();
        check("t2_we",      {31'd0, rf_we}, 32'd1);
        check("t2_waddr",   {27'd0, rf_waddr}, 32'd9);
        check("t2_wdata",   rf_wdata, 32'hDEADBEEF);
        check("t2_pend_clr", pending, 32'h0);

        // 3: starvation forces a drain after 8 pipeline grants
        mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h3;
        tick();
        mdu_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd10;
        for (int i = 1; i <= 8; i++) begin
            wb_data = 32'h100 + 32'(i);
            expect_wr(5'd10, wb_data);
            tick();
            if (i == 7) check("t3_no_stall", {31'd0, wb_stall}, 32'd0);
        end
        check("t3_stall", {31'd0, wb_stall}, 32'd1);
        wb_data = 32'h109;
        expect_wr(5'd3, 32'h3);
        expect_wr(5'd10, 32'h109);
        tick();
        check("t3_force_addr", {27'd0, rf_waddr}, 32'd3);
        check("t3_unstall",    {31'd0, wb_stall}, 32'd0);
        tick();
        check("t3_held_addr",  {27'd0, rf_waddr}, 32'd10);
        wb_we = 1'b0;
        tick();

        // 4a: full backpressure
        wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hB0;
        for (int i = 1; i <= 4; i++) begin
            mdu_valid = 1'b1; mdu_addr = 5'(i); mdu_data = 32'h40 + 32'(i);
            #1;
            check("t4_ready_fill", {31'd0, mdu_ready}, 32'd1);
            expect_wr(5'd11, 32'hB0);
            tick();
        end
        mdu_addr = 5'd8; mdu_data = 32'h48;
        #1;
        check("t4_ready_full", {31'd0, mdu_ready}, 32'd0);
        expect_wr(5'd11, 32'hB0);
        tick();
        check("t4_pending", pending, 32'h1E);
        mdu_valid = 1'b0; wb_we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_wr(5'(i), 32'h40 + 32'(i));
            tick();
        end
        tick();
        check("t4_drained", pending, 32'h0);

        // 4b: duplicate destination waits for its pop
        wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hB1;
        mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h70;
        expect_wr(5'd11, 32'hB1);
        tick();
        mdu_data = 32'h71;
        #1;
        check("t4_dup_ready", {31'd0, mdu_ready}, 32'd0);
        expect_wr(5'd11, 32'hB1);
        tick();
        wb_we = 1'b0;
        #1;
        check("t4_dup_ready2", {31'd0, mdu_ready}, 32'd0);
        expect_wr(5'd7, 32'h70);
        tick();
        check("t4_dup_ready3", {31'd0, mdu_ready}, 32'd1);
        expect_wr(5'd7, 32'h71);
        tick();
        mdu_valid = 1'b0;
        tick();
        tick();
        check("t4_dup_pend", pending, 32'h0);

        // 5: r0 handling
        wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hB2;
        mdu_valid = 1'b1; mdu_addr = 5'd2; mdu_data = 32'h22;
        expect_wr(5'd11, 32'hB2);
        tick();
        wb_addr = 5'd0; wb_data = 32'hEE;
        mdu_addr = 5'd0; mdu_data = 32'h5;
        #1;
        check("t5_r0_ready", {31'd0, mdu_ready}, 32'd1);
        expect_wr(5'd2, 32'h22);
        tick();
        check("t5_r2_addr",  {27'd0, rf_waddr}, 32'd2);
        check("t5_pend",     pending, 32'h0);
        mdu_valid = 1'b0; wb_we = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t5_no_we",    {31'd0, rf_we}, 32'd0);
        check("t5_pend2",    pending, 32'h0);

        // 6: WAW flag
        check("t6_err_pre", {31'd0, err_waw}, 32'd0);
        wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hB3;
        mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'hC0;
        expect_wr(5'd11, 32'hB3);
        tick();
        mdu_valid = 1'b0;
        wb_addr = 5'd12; wb_data = 32'hCC;
        expect_wr(5'd12, 32'hCC);
        tick();
        check("t6_err_set", {31'd0, err_waw}, 32'd1);
        check("t6_pending", pending, 32'h1000);
        wb_we = 1'b0;
        expect_wr(5'd12, 32'hC0);
        tick();
        tick();
        tick();
        check("t6_err_sticky", {31'd0, err_waw}, 32'd1);
        check("t6_pend_clr",   pending, 32'h0);

        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
